// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter. The pipeline write-back always wins; results
// from the multi-cycle unit are buffered in a small FIFO and drained into idle
// write slots. Also provides decode-stage busy lookups and a starvation stall.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_valid,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_data,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] q_addr_a,
  input  logic [ADDR_W-1:0] q_addr_b,
  output logic              q_busy_a,
  output logic              q_busy_b,
  output logic              pipe_stall,
  output logic              proto_err
);

  localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned WaitW = $clog2(STARVE_MAX + 1);

  localparam logic [CntW-1:0]  DepthC = CntW'(DEPTH);
  localparam logic [WaitW-1:0] WaitMx = WaitW'(STARVE_MAX);

  logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              pipe_stall_q, pipe_stall_d;
  logic              proto_err_q, proto_err_d;

  logic              not_full;
  logic              enq;
  logic              deq;
  logic [PtrW-1:0]   idx;

  // Ready comes from the registered count only, so a dequeue never frees a slot
  // for an enqueue in the same cycle. Held low while reset is applied.
  assign not_full = (count_q < DepthC);
  assign m_ready  = rst & not_full;

  // Grant, enqueue/dequeue and next-state for all registered outputs.
  always_comb begin
    enq          = m_valid && not_full;
    deq          = !p_valid && (count_q != '0);
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    wait_cnt_d   = wait_cnt_q;
    pipe_stall_d = 1'b0;
    proto_err_d  = proto_err_q | (p_valid & pipe_stall_q);

    if (p_valid) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = p_addr;
      rf_wdata_d = p_data;
    end else if (deq) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = fifo_addr_q[rd_ptr_q];
      rf_wdata_d = fifo_data_q[rd_ptr_q];
    end

    if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
    if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
    if (enq && !deq) count_d = count_q + 1'b1;
    else if (!enq && deq) count_d = count_q - 1'b1;

    if ((count_q == '0) || deq) wait_cnt_d = '0;
    else if (wait_cnt_q != WaitMx) wait_cnt_d = wait_cnt_q + 1'b1;

    // Stall follows the saturated counter by one cycle and drops once the head moves.
    pipe_stall_d = (wait_cnt_q == WaitMx) && !deq;
  end

  // Control state and registered write-port outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wait_cnt_q   <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      pipe_stall_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      wait_cnt_q   <= wait_cnt_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      pipe_stall_q <= pipe_stall_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // FIFO storage; validity is tracked by pointers/count so no reset is needed.
  always_ff @(posedge clk) begin
    if (rst && enq) begin
      fifo_addr_q[wr_ptr_q] <= m_addr;
      fifo_data_q[wr_ptr_q] <= m_data;
    end
  end

  // Busy lookup over the live window [rd_ptr, rd_ptr + count).
  always_comb begin
    q_busy_a = 1'b0;
    q_busy_b = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PtrW'(i);
      if (CntW'(i) < count_q) begin
        if (fifo_addr_q[idx] == q_addr_a) q_busy_a = 1'b1;
        if (fifo_addr_q[idx] == q_addr_b) q_busy_b = 1'b1;
      end
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign pipe_stall = pipe_stall_q;
  assign proto_err  = proto_err_q;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two producers.
- Producer 1 is the in-order pipeline write-back stage. It cannot be back-pressured and always has priority.
- Producer 2 is a multi-cycle unit (mul/div, late load). It uses a valid/ready handshake and is buffered in a small FIFO.
- Drives registered write signals to the register file. Provides a busy lookup for decode-stage hazard stalls and a starvation stall request to the pipeline.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register index width
DEPTH, 4, multi-cycle FIFO entries (power of 2, >=2)
STARVE_MAX, 4, cycles a FIFO head may wait before pipe_stall asserts (>=1)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous reset, active-low
p_valid  in  1  pipeline write-back request this cycle
p_addr  in  ADDR_W  pipeline destination register
p_data  in  DATA_W  pipeline write data
m_valid  in  1  multi-cycle unit has a result
m_ready  out  1  FIFO can accept (registered: !full)
m_addr  in  ADDR_W  multi-cycle destination register
m_data  in  DATA_W  multi-cycle result
rf_we  out  1  register file write enable (registered)
rf_waddr  out  ADDR_W  register file write index (registered)
rf_wdata  out  DATA_W  register file write data (registered)
q_addr_a  in  ADDR_W  decode source/dest query A
q_addr_b  in  ADDR_W  decode source/dest query B
q_busy_a  out  1  q_addr_a matches a valid FIFO entry (combinational from state)
q_busy_b  out  1  same for q_addr_b
pipe_stall  out  1  request pipeline bubble next write-back slot (registered)
proto_err  out  1  sticky: p_valid seen while pipe_stall=1

Behaviour:
- Reset (rst=0 at posedge):
  - FIFO emptied; wr/rd pointers 0.
  - wait_cnt 0.
  - rf_we 0, rf_waddr 0, rf_wdata 0.
  - m_ready 1 after reset; m_ready=0 during reset cycles.
  - pipe_stall 0, proto_err 0.
  - Reset mid-operation discards buffered entries without writing them.
- Enqueue: on posedge when m_valid && m_ready. Entry {m_addr, m_data} is written at wr_ptr.
  - m_ready is derived from registered count (count<DEPTH).
  - When full, no enqueue occurs even if a dequeue happens that cycle. m_ready rises the cycle after.
- Grant, evaluated each cycle:
  - If p_valid: pipeline granted.
  - Else if FIFO non-empty: head granted and dequeued at posedge.
  - Else: no write.
- Output latency: grant in cycle N produces rf_we=1 with the matching addr/data in cycle N+1, held exactly one cycle.
  - rf_we=0 in cycle N+1 if no grant in cycle N.
  - rf_waddr/rf_wdata hold their last values when rf_we=0.
- No special handling of register 0; addresses pass through unchanged.
- Count: +1 on enqueue only, -1 on dequeue only, unchanged when both occur. Pointers wrap modulo DEPTH.
- Enqueue to an empty FIFO: the entry is not eligible for grant until the following cycle (no bypass).
- Starvation:
  - wait_cnt clears to 0 when the FIFO is empty or the head dequeues.
  - Otherwise it increments, saturating at STARVE_MAX.
  - pipe_stall is registered: 1 in the cycle after wait_cnt reaches STARVE_MAX; cleared the cycle after a dequeue.
- Environment rule: p_valid=0 in every cycle with pipe_stall=1.
  - On violation, the pipeline still wins the grant and proto_err sets.
  - proto_err stays set until reset.
- Busy query: q_busy_x=1 iff any valid FIFO entry (between rd_ptr and wr_ptr) has addr==q_addr_x.
  - The entry being enqueued this cycle is excluded.
  - The entry in the rf_* output register is excluded.
  - Decode uses q_busy to stall, preventing a newer pipeline write being overwritten by an older buffered result.

Test Plan:
- Reset then idle → rf_we=0, m_ready=1, pipe_stall=0, q_busy_a=0 for all addresses.
- p_valid=1, p_addr=3, p_data=0x21 at cycle N → rf_we=1, rf_waddr=3, rf_wdata=0x21 at N+1 only; rf_we=0 at N+2.
- DEPTH=4: enqueue 4 results (r8=8…r11=11) while p_valid=1 continuously → m_ready=0 after 4th; pipe_stall=1 after STARVE_MAX waiting cycles; drop p_valid → entries drain in FIFO order r8,r9,r10,r11, one per cycle; m_ready=1 the cycle after first dequeue; pipe_stall clears.
- Simultaneous enqueue r5 and dequeue with count=2 → count stays 2; q_busy_a for q_addr_a=5 becomes 1 the next cycle; wrap of wr_ptr past DEPTH-1 is correct.
- p_valid=1 while pipe_stall=1 → pipeline write performed, head not dequeued, proto_err=1 and held until rst=0.
- Assert rst=0 with 3 entries buffered → next cycle count=0, rf_we=0, no buffered writes ever appear on rf_*.
